// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encoding and default
// frame-sync constants.
package tdm_demux_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_e;

    localparam int unsigned SYNC_LEN_DEF  = 8;
    localparam logic [7:0]  SYNC_WORD_DEF = 8'hA5;

endpackage : tdm_demux_pkg

// File: rtl/tdm_sync_detect.sv
// Sync-word detector: SYNC_LEN-bit serial window plus comparator.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   shift_i     shift bit_i into the window this cycle
//   clear_i     zero the window (takes priority over shift_i)
//   bit_i       serial input bit
//   match_c_o   combinational: window including bit_i equals SYNC_WORD
module tdm_sync_detect
    import tdm_demux_pkg::*;
#(
    parameter int unsigned           SYNC_LEN  = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0]   SYNC_WORD = SYNC_LEN'(SYNC_WORD_DEF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_i,
    input  logic clear_i,
    input  logic bit_i,
    output logic match_c_o
);

    logic [SYNC_LEN-1:0] window_q;
    logic [SYNC_LEN-1:0] window_d;
    logic [SYNC_LEN-1:0] win_next;

    // Window as it will look once bit_i is shifted in; match is judged on this.
    assign win_next  = {window_q[SYNC_LEN-2:0], bit_i};
    assign match_c_o = shift_i && (win_next == SYNC_WORD);

    always_comb begin
        window_d = window_q;
        if (clear_i) begin
            window_d = '0;
        end else if (shift_i) begin
            window_d = win_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

endmodule : tdm_sync_detect

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: hunts for the frame sync word, then distributes each
// frame's payload to N_CH parallel channel registers, with flywheel tolerance
// of up to MISS_MAX-1 consecutive sync errors.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   din          serial data bit, MSB first, channel 0 first
//   din_valid    din is sampled only when 1
//   ch_data      latest payload, channel k at [k*CH_W +: CH_W]
//   frame_valid  one-cycle pulse when ch_data has just been updated
//   locked       frame alignment held
//   sync_err     one-cycle pulse per sync mismatch while locked
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned         N_CH      = 4,
    parameter int unsigned         CH_W      = 8,
    parameter int unsigned         SYNC_LEN  = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(SYNC_WORD_DEF),
    parameter int unsigned         MISS_MAX  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_valid,
    output logic [N_CH*CH_W-1:0] ch_data,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int unsigned PAY_W  = N_CH * CH_W;
    localparam int unsigned CNT_W  = $clog2((PAY_W > SYNC_LEN) ? PAY_W : SYNC_LEN) + 1;
    localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [MISS_W-1:0]  miss_inc;
    logic [PAY_W-1:0]   payload_q, payload_d;
    logic [PAY_W-1:0]   pay_next;
    logic [PAY_W-1:0]   ch_next;
    logic [PAY_W-1:0]   ch_data_q, ch_data_d;
    logic               frame_valid_q, frame_valid_d;
    logic               locked_q, locked_d;
    logic               sync_err_q, sync_err_d;
    logic               win_shift, win_clear, sync_match;

    tdm_sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_i   (win_shift),
        .clear_i   (win_clear),
        .bit_i     (din),
        .match_c_o (sync_match)
    );

    assign pay_next = {payload_q[PAY_W-2:0], din};
    assign miss_inc = miss_q + MISS_W'(1);

    // Channel 0 arrives first, so it ends up in the top slice of the shift register.
    always_comb begin
        ch_next = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            ch_next[k*CH_W +: CH_W] = pay_next[(int'(N_CH) - 1 - k)*CH_W +: CH_W];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        miss_d        = miss_q;
        payload_d     = payload_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        locked_d      = locked_q;
        win_shift     = 1'b0;
        win_clear     = 1'b0;

        unique case (state_q)
            HUNT: begin
                win_shift = din_valid;
                if (din_valid && sync_match) begin
                    state_d   = PAYLOAD;
                    bit_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                if (din_valid) begin
                    payload_d = pay_next;
                    if (bit_cnt_q == CNT_W'(PAY_W - 1)) begin
                        ch_data_d     = ch_next;
                        frame_valid_d = 1'b1;
                        locked_d      = 1'b1;
                        state_d       = CHECK;
                        bit_cnt_d     = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                win_shift = din_valid;
                if (din_valid) begin
                    if (bit_cnt_q == CNT_W'(SYNC_LEN - 1)) begin
                        bit_cnt_d = '0;
                        if (sync_match) begin
                            miss_d  = '0;
                            state_d = PAYLOAD;
                        end else begin
                            sync_err_d = 1'b1;
                            if (miss_inc == MISS_W'(MISS_MAX)) begin
                                locked_d  = 1'b0;
                                miss_d    = '0;
                                state_d   = HUNT;
                                win_clear = 1'b1;
                            end else begin
                                miss_d  = miss_inc;
                                state_d = PAYLOAD;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = HUNT;
                bit_cnt_d = '0;
                miss_d    = '0;
                locked_d  = 1'b0;
                win_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            bit_cnt_q     <= '0;
            miss_q        <= '0;
            payload_q     <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            miss_q        <= miss_d;
            payload_q     <= payload_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule : tdm_demux

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Serial time-division demultiplexer: receives a 1-bit framed stream, finds the frame sync word, and distributes each frame's payload to N_CH parallel channel registers.
- Receive-side counterpart of the team's multiplexer/selector blocks; sits between a serial link input and per-channel consumer logic.
- Includes a sync hunt/lock state machine with flywheel tolerance of isolated sync errors.

Parameters:
- N_CH, 4, number of channels per frame.
- CH_W, 8, bits per channel.
- SYNC_LEN, 8, sync word length in bits.
- SYNC_WORD, 8'hA5, sync pattern; first transmitted bit is the MSB.
- MISS_MAX, 2, consecutive sync mismatches that drop lock.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only on cycles where this is 1.
- ch_data  output  N_CH*CH_W  latest frame payload; channel k occupies bits [k*CH_W +: CH_W].
- frame_valid  output  1  one-cycle pulse: ch_data has just been updated.
- locked  output  1  frame alignment held.
- sync_err  output  1  one-cycle pulse on each sync mismatch while locked.

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT; ch_data=0, frame_valid=0, locked=0, sync_err=0; shift registers, bit counter and miss counter=0. Reset asserted mid-frame discards the partial frame.
- Bit sampling: a bit is accepted only when din_valid=1. With din_valid=0, state, counters and shift registers hold, and frame_valid and sync_err are 0.
- Bit order: MSB first for the sync word and for each channel; channel 0 is transmitted first.
- HUNT:
  - Shift each accepted bit into a SYNC_LEN-bit window.
  - When the window, including the bit just accepted, equals SYNC_WORD, go to PAYLOAD with bit_cnt=0.
  - locked stays 0.
- PAYLOAD:
  - Shift accepted bits into the payload register; bit_cnt counts 0..N_CH*CH_W-1.
  - On the edge that accepts the last payload bit: load ch_data; assert frame_valid for exactly the next cycle; set locked=1; go to CHECK with bit_cnt=0.
  - Latency: ch_data is valid 1 clock after the last payload bit is sampled.
- CHECK:
  - Collect SYNC_LEN accepted bits.
  - On the edge that accepts the last sync bit, if they match SYNC_WORD: miss_cnt=0, go to PAYLOAD.
  - On mismatch: pulse sync_err for one cycle; miss_cnt=miss_cnt+1.
    - If the new miss_cnt equals MISS_MAX: locked=0, miss_cnt=0, go to HUNT with the window cleared.
    - Otherwise go to PAYLOAD (flywheel). The following frame is still delivered with frame_valid.
- In HUNT, ch_data holds its last value.
- No sync search inside PAYLOAD: payload bits equal to SYNC_WORD are never treated as sync.
- The bit counter wraps only by explicit reset to 0 at each state transition. Its width is $clog2(max(N_CH*CH_W, SYNC_LEN)) + 1.
- sync_err and frame_valid are never asserted in the same cycle, because they occur in different states.

Decomposition:
- Shared package/header: state encodings HUNT=2'd0, PAYLOAD=2'd1, CHECK=2'd2, and the default SYNC_WORD/SYNC_LEN constants.
- One natural sub-module: tdm_sync_detect. It holds the SYNC_LEN shift window and comparator, is used in HUNT and CHECK, and outputs a match flag. The FSM, counters and payload register stay in tdm_demux.

Test Plan:
- Aligned lock: defaults; send A5,11,22,33,44 with din_valid=1 continuously -> ch_data=32'h44332211, frame_valid high for exactly 1 cycle after the last bit, locked=1.
- Hunt with garbage: send prefix bits 1,0,1,1 and then the same frame -> identical result. Separately, send payload byte A5 in a locked frame -> no realignment.
- Flywheel: locked; send sync 00 followed by payload 01,02,03,04; then sync A5 with payload 05,06,07,08 -> one sync_err pulse; locked stays 1; ch_data=32'h04030201 then 32'h08070605, each with a frame_valid pulse.
- Loss of lock: locked; two consecutive frames with sync 00 -> two sync_err pulses; locked=0 after the second; a following A5 frame relocks.
- Stall: repeat the aligned-lock frame with din_valid toggled pseudo-randomly at ~50% -> same ch_data, one frame_valid pulse, no pulses during stall cycles.
- Reset mid-frame: assert rst_n=0 after 12 payload bits -> all outputs 0 immediately; after release, a full frame A5,AA,BB,CC,DD gives ch_data=32'hDDCCBBAA.
